// File: rtl/execute_hazard_controller.sv
// Purpose : execute-stage hazard control. Forwarding selects, load-use bubble, wrong-path flush after redirect.
// Latency : outputs are combinational from state, scoreboard and decode inputs; forwarding selects take effect the same cycle.
// Backpres: one-cycle stallFetch/stallDecode on load-use. A flush never stalls fetch, it only bubbles execute.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   idValid, idOpcode          decode-stage instruction valid and opcode
//   idRs1, idRs2, idRd         decode-stage register indices
//   pcWriteEnable              execute-stage PC redirect (taken branch, jal, jalr)
//   stallFetch, stallDecode    hold PC/fetch register and decode register
//   hazard                     inject a bubble into execute this cycle
//   forward0Sel, forward1Sel   operand source: 0 regfile, 1 execute ALU result, 2 writeback data
//   flushActive                redirect squash window in progress
module execute_hazard_controller #(
   parameter int RegAddrWidth = 5,
   parameter int FlushCycles  = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    idValid,
   input  logic [6:0]              idOpcode,
   input  logic [RegAddrWidth-1:0] idRs1,
   input  logic [RegAddrWidth-1:0] idRs2,
   input  logic [RegAddrWidth-1:0] idRd,
   input  logic                    pcWriteEnable,
   output logic                    stallFetch,
   output logic                    stallDecode,
   output logic                    hazard,
   output logic [1:0]              forward0Sel,
   output logic [1:0]              forward1Sel,
   output logic                    flushActive
);

   localparam logic [6:0] OpR      = 7'b0110011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;

   localparam logic [1:0] CntReload = 2'(FlushCycles - 1);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_STALL,   // cycle after a load-use bubble: the held instruction replays
      ST_FLUSH
   } state_t;

   typedef struct packed {
      logic                    vld;
      logic [RegAddrWidth-1:0] rd;
      logic                    is_load;
   } sb_entry_t;

   state_t    state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   sb_entry_t ex_q, ex_d;
   sb_entry_t wb_q;

   // ---------------- opcode class ----------------
   logic writes_rd, reads_rs1, reads_rs2, is_load;

   always_comb begin
      writes_rd = 1'b0;
      reads_rs1 = 1'b0;
      reads_rs2 = 1'b0;
      is_load   = 1'b0;
      case (idOpcode)
         OpR:      begin writes_rd = 1'b1; reads_rs1 = 1'b1; reads_rs2 = 1'b1; end
         OpImm:    begin writes_rd = 1'b1; reads_rs1 = 1'b1; end
         OpLoad:   begin writes_rd = 1'b1; reads_rs1 = 1'b1; is_load = 1'b1; end
         OpStore:  begin reads_rs1 = 1'b1; reads_rs2 = 1'b1; end
         OpBranch: begin reads_rs1 = 1'b1; reads_rs2 = 1'b1; end
         OpJalr:   begin writes_rd = 1'b1; reads_rs1 = 1'b1; end
         OpJal, OpLui, OpAuipc: writes_rd = 1'b1;
         default:  ;
      endcase
   end

   // ---------------- operand matching ----------------
   // An operand only participates when the instruction is valid, reads it, and it is not x0.
   logic use_rs1, use_rs2;
   logic ex_hit1, ex_hit2, wb_hit1, wb_hit2;
   logic load_use;

   assign use_rs1 = idValid && reads_rs1 && (idRs1 != '0);
   assign use_rs2 = idValid && reads_rs2 && (idRs2 != '0);
   assign ex_hit1 = use_rs1 && ex_q.vld && (ex_q.rd == idRs1);
   assign ex_hit2 = use_rs2 && ex_q.vld && (ex_q.rd == idRs2);
   assign wb_hit1 = use_rs1 && wb_q.vld && (wb_q.rd == idRs1);
   assign wb_hit2 = use_rs2 && wb_q.vld && (wb_q.rd == idRs2);

   // A load in execute has no result yet, so it cannot forward and must bubble its consumer.
   assign load_use = (ex_hit1 || ex_hit2) && ex_q.is_load;

   logic [1:0] fwd0_raw, fwd1_raw;

   always_comb begin
      fwd0_raw = 2'd0;
      fwd1_raw = 2'd0;
      if (ex_hit1 && !ex_q.is_load) fwd0_raw = 2'd1;
      else if (wb_hit1)             fwd0_raw = 2'd2;
      if (ex_hit2 && !ex_q.is_load) fwd1_raw = 2'd1;
      else if (wb_hit2)             fwd1_raw = 2'd2;
   end

   // ---------------- control ----------------
   logic in_flush, load_stall;

   assign in_flush   = (state_q == ST_FLUSH);
   // A redirect in the same cycle makes the consumer wrong-path, so the bubble is dropped.
   assign load_stall = !in_flush && load_use && !pcWriteEnable;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_RUN, ST_STALL: begin
            if (pcWriteEnable) begin
               state_d = ST_FLUSH;
               cnt_d   = CntReload;
            end else if (load_stall) begin
               state_d = ST_STALL;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_FLUSH: begin
            if (pcWriteEnable) begin
               cnt_d = CntReload;
            end else if (cnt_q == 2'd0) begin
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         default: begin
            state_d = ST_RUN;
            cnt_d   = 2'd0;
         end
      endcase
   end

   // Decode instruction enters the scoreboard unless bubbled or squashed.
   always_comb begin
      ex_d = '0;
      if (!load_stall && !in_flush) begin
         ex_d.vld     = idValid && writes_rd && (idRd != '0);
         ex_d.rd      = idRd;
         ex_d.is_load = is_load;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RUN;
         cnt_q   <= 2'd0;
         ex_q    <= '0;
         wb_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ex_q    <= ex_d;
         wb_q    <= ex_q;
      end
   end

   // ---------------- outputs ----------------
   // Gated with reset so outputs are quiet during reset regardless of prior state.
   assign stallFetch  = !reset && load_stall;
   assign stallDecode = !reset && load_stall;
   assign hazard      = !reset && (load_stall || in_flush);
   assign flushActive = !reset && in_flush;
   assign forward0Sel = (reset || hazard) ? 2'd0 : fwd0_raw;
   assign forward1Sel = (reset || hazard) ? 2'd0 : fwd1_raw;

endmodule

// File: tb/tb_execute_hazard_controller.sv
module tb_execute_hazard_controller;

   localparam logic [6:0] R   = 7'b0110011;
   localparam logic [6:0] I   = 7'b0010011;
   localparam logic [6:0] LD  = 7'b0000011;
   localparam logic [6:0] BR  = 7'b1100011;
   localparam logic [6:0] JAL = 7'b1101111;
   localparam logic [6:0] LUI = 7'b0110111;
   localparam logic [6:0] UNK = 7'b1111111;

   // expected vector: {stallFetch, stallDecode, hazard, flushActive, forward0Sel, forward1Sel}
   localparam logic [7:0] QUIET = 8'b0000_00_00;
   localparam logic [7:0] STALL = 8'b1110_00_00;
   localparam logic [7:0] FLUSH = 8'b0011_00_00;

   typedef struct packed {
      logic       rst;
      logic       v;
      logic [6:0] op;
      logic [4:0] r1;
      logic [4:0] r2;
      logic [4:0] rd;
      logic       pcw;
      logic [7:0] exp;
   } step_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       idValid;
   logic [6:0] idOpcode;
   logic [4:0] idRs1, idRs2, idRd;
   logic       pcWriteEnable;
   logic       stallFetch, stallDecode, hazard, flushActive;
   logic [1:0] forward0Sel, forward1Sel;

   int pass_cnt  = 0;
   int total_cnt = 0;

   execute_hazard_controller #(.RegAddrWidth(5), .FlushCycles(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .idValid      (idValid),
      .idOpcode     (idOpcode),
      .idRs1        (idRs1),
      .idRs2        (idRs2),
      .idRd         (idRd),
      .pcWriteEnable(pcWriteEnable),
      .stallFetch   (stallFetch),
      .stallDecode  (stallDecode),
      .hazard       (hazard),
      .forward0Sel  (forward0Sel),
      .forward1Sel  (forward1Sel),
      .flushActive  (flushActive)
   );

   always #5 clk = ~clk;

   function automatic step_t mk(input logic rst, input logic v, input logic [6:0] op,
                                input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                                input logic pcw, input logic [7:0] exp);
      step_t s;
      s.rst = rst; s.v = v; s.op = op; s.r1 = r1; s.r2 = r2; s.rd = rd; s.pcw = pcw; s.exp = exp;
      return s;
   endfunction

   function automatic logic [7:0] obs();
      return {stallFetch, stallDecode, hazard, flushActive, forward0Sel, forward1Sel};
   endfunction

   // inputs change on the falling edge; outputs are sampled 2 ns later
   task automatic apply(input step_t s);
      reset         = s.rst;
      idValid       = s.v;
      idOpcode      = s.op;
      idRs1         = s.r1;
      idRs2         = s.r2;
      idRd          = s.rd;
      pcWriteEnable = s.pcw;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         apply(mk(0, 0, 7'd0, 0, 0, 0, 0, QUIET));
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      step_t s [4];
      logic [7:0] got;
      s[0] = mk(1, 1, LD, 1, 0, 5, 0, QUIET);   // lw x5 under reset
      s[1] = mk(1, 1, R,  5, 5, 6, 1, QUIET);   // add x6,x5,x5 and redirect under reset
      s[2] = mk(0, 1, R,  5, 5, 6, 0, QUIET);   // first cycle out of reset: nothing in flight
      s[3] = mk(0, 0, R,  6, 6, 7, 0, QUIET);
      for (int i = 0; i < 4; i++) begin
         apply(s[i]); #2;
         got = obs();
         total_cnt++;
         if (got !== s[i].exp) $display("FAIL reset step %0d: got %b expected %b", i, got, s[i].exp);
         else pass_cnt++;
         @(negedge clk);
      end
      idle(2);
   endtask

   task automatic test_alu_forward();
      step_t s [7];
      logic [7:0] got;
      s[0] = mk(0, 1, R, 1, 2, 5, 0, QUIET);          // add x5,x1,x2
      s[1] = mk(0, 1, R, 5, 3, 6, 0, 8'b0000_01_00);  // sub x6,x5,x3
      s[2] = mk(0, 1, R, 4, 5, 7, 0, 8'b0000_00_10);  // or  x7,x4,x5
      s[3] = mk(0, 1, R, 7, 6, 8, 0, 8'b0000_01_10);  // add x8,x7,x6
      s[4] = mk(0, 1, I, 0, 8, 10, 0, QUIET);         // addi x10,x0,1 (rs2 field unused)
      s[5] = mk(0, 1, I, 10, 10, 10, 0, 8'b0000_01_00); // addi x10,x10,1
      s[6] = mk(0, 1, R, 10, 10, 11, 0, 8'b0000_01_01); // add x11,x10,x10: ex beats wb
      for (int i = 0; i < 7; i++) begin
         apply(s[i]); #2;
         got = obs();
         total_cnt++;
         if (got !== s[i].exp) $display("FAIL alu_forward step %0d: got %b expected %b", i, got, s[i].exp);
         else pass_cnt++;
         @(negedge clk);
      end
      idle(2);
   endtask

   task automatic test_load_use();
      step_t s [4];
      logic [7:0] got;
      s[0] = mk(0, 1, LD, 1, 0, 5, 0, QUIET);          // lw x5,0(x1)
      s[1] = mk(0, 1, R,  5, 5, 6, 0, STALL);          // add x6,x5,x5
      s[2] = mk(0, 1, R,  5, 5, 6, 0, 8'b0000_10_10);  // held add replays from wb
      s[3] = mk(0, 1, R,  6, 5, 7, 0, 8'b0000_01_00);  // sub x7,x6,x5: load has retired
      for (int i = 0; i < 4; i++) begin
         apply(s[i]); #2;
         got = obs();
         total_cnt++;
         if (got !== s[i].exp) $display("FAIL load_use step %0d: got %b expected %b", i, got, s[i].exp);
         else pass_cnt++;
         @(negedge clk);
      end
      idle(2);
   endtask

   task automatic test_back_to_back();
      step_t s [5];
      logic [7:0] got;
      s[0] = mk(0, 1, LD, 1, 0, 5, 0, QUIET);          // lw x5,0(x1)
      s[1] = mk(0, 1, LD, 5, 5, 6, 0, STALL);          // lw x6,0(x5)
      s[2] = mk(0, 1, LD, 5, 5, 6, 0, 8'b0000_10_00);  // replay; rs2 field not read
      s[3] = mk(0, 1, R,  6, 1, 7, 0, STALL);          // add x7,x6,x1: second own stall
      s[4] = mk(0, 1, R,  6, 1, 7, 0, 8'b0000_10_00);
      for (int i = 0; i < 5; i++) begin
         apply(s[i]); #2;
         got = obs();
         total_cnt++;
         if (got !== s[i].exp) $display("FAIL back_to_back step %0d: got %b expected %b", i, got, s[i].exp);
         else pass_cnt++;
         @(negedge clk);
      end
      idle(2);
   endtask

   task automatic test_x0_unused();
      step_t s [6];
      logic [7:0] got;
      s[0] = mk(0, 1, I,   0, 0, 0, 0, QUIET);          // addi x0,x0,1
      s[1] = mk(0, 1, R,   0, 0, 1, 0, QUIET);          // add x1,x0,x0
      s[2] = mk(0, 1, LUI, 1, 1, 5, 0, QUIET);          // lui x5: fields not read
      s[3] = mk(0, 1, JAL, 5, 5, 1, 0, QUIET);          // jal x1: fields not read
      s[4] = mk(0, 1, BR,  1, 5, 0, 0, 8'b0000_01_10);  // beq x1,x5
      s[5] = mk(0, 1, UNK, 1, 1, 1, 0, QUIET);          // unknown opcode reads nothing
      for (int i = 0; i < 6; i++) begin
         apply(s[i]); #2;
         got = obs();
         total_cnt++;
         if (got !== s[i].exp) $display("FAIL x0_unused step %0d: got %b expected %b", i, got, s[i].exp);
         else pass_cnt++;
         @(negedge clk);
      end
      idle(2);
   endtask

   task automatic test_flush();
      step_t s [9];
      logic [7:0] got;
      s[0] = mk(0, 0, 7'd0, 0, 0, 0, 1, QUIET);         // redirect pulse
      s[1] = mk(0, 1, I, 1, 0, 9, 0, FLUSH);            // addi x9 squashed
      s[2] = mk(0, 1, I, 1, 0, 9, 0, FLUSH);            // addi x9 squashed
      s[3] = mk(0, 1, R, 9, 9, 10, 0, QUIET);           // no forward on x9
      s[4] = mk(0, 0, 7'd0, 0, 0, 0, 1, QUIET);         // redirect pulse
      s[5] = mk(0, 0, 7'd0, 0, 0, 0, 1, FLUSH);         // re-pulse in flush cycle 1
      s[6] = mk(0, 0, 7'd0, 0, 0, 0, 0, FLUSH);
      s[7] = mk(0, 0, 7'd0, 0, 0, 0, 0, FLUSH);
      s[8] = mk(0, 0, 7'd0, 0, 0, 0, 0, QUIET);
      for (int i = 0; i < 9; i++) begin
         apply(s[i]); #2;
         got = obs();
         total_cnt++;
         if (got !== s[i].exp) $display("FAIL flush step %0d: got %b expected %b", i, got, s[i].exp);
         else pass_cnt++;
         @(negedge clk);
      end
      idle(2);
   endtask

   task automatic test_stall_redirect();
      step_t s [6];
      logic [7:0] got;
      s[0] = mk(0, 1, LD, 1, 0, 5, 0, QUIET);
      s[1] = mk(0, 1, R,  5, 5, 6, 0, STALL);
      s[2] = mk(0, 1, R,  5, 5, 6, 1, 8'b0000_10_10);  // redirect during replay cycle
      s[3] = mk(0, 0, 7'd0, 0, 0, 0, 0, FLUSH);
      s[4] = mk(0, 0, 7'd0, 0, 0, 0, 0, FLUSH);
      s[5] = mk(0, 0, 7'd0, 0, 0, 0, 0, QUIET);
      for (int i = 0; i < 6; i++) begin
         apply(s[i]); #2;
         got = obs();
         total_cnt++;
         if (got !== s[i].exp) $display("FAIL stall_redirect step %0d: got %b expected %b", i, got, s[i].exp);
         else pass_cnt++;
         @(negedge clk);
      end
      idle(2);
   endtask

   task automatic test_priority();
      step_t s [8];
      logic [7:0] got;
      s[0] = mk(0, 1, LD, 1, 0, 5, 0, QUIET);          // lw x5
      s[1] = mk(0, 1, R,  5, 5, 6, 1, QUIET);          // load-use + redirect: no stall
      s[2] = mk(0, 0, 7'd0, 0, 0, 0, 0, FLUSH);
      s[3] = mk(0, 0, 7'd0, 0, 0, 0, 0, FLUSH);
      s[4] = mk(0, 0, 7'd0, 0, 0, 0, 0, QUIET);
      s[5] = mk(0, 1, R,  1, 1, 7, 1, QUIET);          // add x7 enters ex, redirect
      s[6] = mk(1, 1, R,  7, 7, 8, 0, QUIET);          // reset in flush cycle 1
      s[7] = mk(0, 1, R,  7, 7, 8, 0, QUIET);          // RUN, scoreboard cleared
      for (int i = 0; i < 8; i++) begin
         apply(s[i]); #2;
         got = obs();
         total_cnt++;
         if (got !== s[i].exp) $display("FAIL priority step %0d: got %b expected %b", i, got, s[i].exp);
         else pass_cnt++;
         @(negedge clk);
      end
      idle(2);
   endtask

   initial begin
      apply(mk(1, 0, 7'd0, 0, 0, 0, 0, QUIET));
      @(negedge clk);
      test_reset();
      test_alu_forward();
      test_load_use();
      test_back_to_back();
      test_x0_unused();
      test_flush();
      test_stall_redirect();
      test_priority();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
